mips_regfile_param: RTL and testbench
=====================================

// Module: mips_regfile_param
// PURPOSE
//   Parametrised successor to the dual-write MIPS register file. Adds width/depth
//   parameters, a synchronous active-low reset and an initialisation sweep that
//   clears the array one entry per cycle, so the array contains no reset logic.
//   Also adds deterministic write-collision priority and optional write-to-read
//   bypass. Sits between decode (read) and writeback (two write ports).
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W     5  address width; DEPTH = 2**ADDR_W entries
//   ZERO_REG   1  1: entry 0 reads as 0 and ignores writes; 0: entry 0 is an ordinary register
//   BYPASS     1  1: same-cycle write data forwarded to reads; 0: reads return stored value
// PORTS
//   clk                input   1       clock; all state updates on posedge
//   rst_n              input   1       synchronous active-low reset
//   read_reg_1         input   ADDR_W  read address, port 1
//   read_reg_2         input   ADDR_W  read address, port 2
//   read_data_1        output  DATA_W  read data, port 1 (combinational)
//   read_data_2        output  DATA_W  read data, port 2 (combinational)
//   write_reg          input   ADDR_W  write address, port 1
//   write_data         input   DATA_W  write data, port 1
//   signal_reg_write   input   1       write enable, port 1
//   write_reg2         input   ADDR_W  write address, port 2
//   write_data2        input   DATA_W  write data, port 2
//   signal_reg_write2  input   1       write enable, port 2
//   ready              output  1       1 = sweep complete; array usable
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-low (rst_n), sampled on posedge clk.
// - FSM states: SWEEP, RUN; sweep counter idx[ADDR_W-1:0].
//   - rst_n=0 at a posedge: state<=SWEEP, idx<=0, ready<=0. No array write in that cycle.
//   - SWEEP with rst_n=1: registers[idx]<=0 and idx<=idx+1.
//   - When idx==DEPTH-1: state<=RUN and ready<=1 on that same edge.
//   - Cycle count: ready rises on the DEPTH-th posedge after rst_n is first sampled high.
//   - RUN is held until the next reset.
// - Reset mid-sweep or in RUN: the sweep restarts from idx=0. Prior contents are
//   don't-care until they are cleared again.
// - While ready=0:
//   - Both write ports are ignored.
//   - read_data_1 and read_data_2 are forced to 0.
// - RUN write:
//   - Port n writes on posedge when its enable is 1.
//   - With ZERO_REG=1, a write to address 0 is dropped.
//   - Both ports enabled to the same address: port 2 (write_data2) wins, and port 1 has
//     no effect.
//   - Different addresses: both writes happen in the same cycle.
// - RUN read (combinational, same-cycle):
//   - With ZERO_REG=1 and address 0, the read returns 0 (overrides bypass).
//   - Else, with BYPASS=1 and a matching enabled, non-dropped write in the same cycle,
//     the read returns that write's data. Port 2 takes priority if both ports match.
//   - Else the read returns registers[addr].
// - Width rules: addresses use all ADDR_W bits. No truncation or sign handling.
// - X on an unused enable/address while its enable is 0 must not corrupt state.
// TESTING
// 1. Reset: rst_n=0 for 2 cycles, then 1. ready=0 for exactly 32 posedges, then 1.
//    All 32 entries read 0.
// 2. Collision: write_reg=write_reg2=7, data 0x1111_1111 / 0x2222_2222, both enabled.
//    Next cycle reg 7 = 0x2222_2222.
// 3. Zero register: both ports write 0xDEAD_BEEF to address 0. read_reg_1=0 returns 0
//    in the write cycle and after it.
// 4. Bypass: in the same cycle write reg 5 = 0xA5A5_A5A5 and read_reg_1=5.
//    BYPASS=1 returns 0xA5A5_A5A5 that cycle. BYPASS=0 returns the old value, and the
//    new value the next cycle.
// 5. Mid-sweep reset: assert rst_n=0 at sweep cycle 10, then release. ready rises 32
//    edges after release. A write issued during the sweep is lost (reads 0 after ready).
// 6. Params DATA_W=64, ADDR_W=3, ZERO_REG=0: sweep takes 8 cycles. Reg 0 holds
//    0x0123_4567_89AB_CDEF after a write.

Source files
------------

// File: rtl/mips_regfile_param.sv
// mips_regfile_param
// Parametrised dual-write, dual-read MIPS register file. After reset the array
// is cleared by a sweep that zeroes one entry per clock, so the storage itself
// carries no reset logic. Port 2 wins write collisions. Same-cycle write data
// can optionally be forwarded to the read ports.
module mips_regfile_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_reg_1,
   input  logic [ADDR_W-1:0] read_reg_2,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic              signal_reg_write,
   input  logic [ADDR_W-1:0] write_reg2,
   input  logic [DATA_W-1:0] write_data2,
   input  logic              signal_reg_write2,
   output logic              ready
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_idx;
   logic                r_ready;
   logic [DATA_W-1:0]   r_regs [DEPTH];

   logic                w_we1;
   logic                w_we2;

   // True when a write to this address must be discarded (hard-wired zero entry).
   function automatic logic addr_dropped(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == ZERO_ADDR);
   endfunction

   // Read-port selection: not-ready forcing, zero entry, bypass (port 2 first), storage.
   function automatic logic [DATA_W-1:0] sel_read(
      input logic              rdy,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] stored,
      input logic              we1,
      input logic [ADDR_W-1:0] waddr1,
      input logic [DATA_W-1:0] wdata1,
      input logic              we2,
      input logic [ADDR_W-1:0] waddr2,
      input logic [DATA_W-1:0] wdata2
   );
      logic [DATA_W-1:0] v;
      if (!rdy) begin
         v = {DATA_W{1'b0}};
      end else if (addr_dropped(addr)) begin
         v = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && we2 && (waddr2 == addr)) begin
         v = wdata2;
      end else if ((BYPASS != 0) && we1 && (waddr1 == addr)) begin
         v = wdata1;
      end else begin
         v = stored;
      end
      return v;
   endfunction

   // Effective write enables: only after the sweep, never to the dropped zero entry.
   // The enable is evaluated first so an X address on an idle port stays harmless.
   assign w_we1 = r_ready && signal_reg_write  && !addr_dropped(write_reg);
   assign w_we2 = r_ready && signal_reg_write2 && !addr_dropped(write_reg2);

   assign ready = r_ready;

   // Sweep/run controller: restart the clearing sweep on reset, raise ready on the last entry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_SWEEP;
         r_idx   <= ZERO_ADDR;
         r_ready <= 1'b0;
      end else begin
         case (r_state)
            ST_SWEEP: begin
               r_idx <= r_idx + ADDR_W'(1'b1);
               if (r_idx == LAST_IDX) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
               end else begin
                  r_state <= ST_SWEEP;
                  r_ready <= 1'b0;
               end
            end
            ST_RUN: begin
               r_state <= ST_RUN;
               r_ready <= 1'b1;
            end
            default: begin
               r_state <= ST_SWEEP;
               r_idx   <= ZERO_ADDR;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   // Storage: sweep clears one entry per cycle; in run, port 2 is applied last so it wins collisions.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == ST_SWEEP) begin
            r_regs[r_idx] <= {DATA_W{1'b0}};
         end else begin
            if (w_we1) begin
               r_regs[write_reg] <= write_data;
            end
            if (w_we2) begin
               r_regs[write_reg2] <= write_data2;
            end
         end
      end
   end

   assign read_data_1 = sel_read(r_ready, read_reg_1, r_regs[read_reg_1],
                                 w_we1, write_reg, write_data,
                                 w_we2, write_reg2, write_data2);
   assign read_data_2 = sel_read(r_ready, read_reg_2, r_regs[read_reg_2],
                                 w_we1, write_reg, write_data,
                                 w_we2, write_reg2, write_data2);

endmodule

// File: tb/tb_mips_regfile_param.sv
// Testbench for mips_regfile_param: three instances (default, no-bypass, and a
// 64-bit / 8-entry / no-zero-register variant) driven by directed steps, with
// expected values queued when stimulus is applied and compared at sample time.
module tb_mips_regfile_param;

   logic        clk;
   logic        rst_n;

   // shared stimulus for the 32x32 instances
   logic [4:0]  read_reg_1, read_reg_2, write_reg, write_reg2;
   logic [31:0] write_data, write_data2;
   logic        signal_reg_write, signal_reg_write2;

   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic        a_rdy, b_rdy;

   // stimulus for the 64x8 instance
   logic [2:0]  c_rr1, c_rr2, c_wr, c_wr2;
   logic [63:0] c_wd, c_wd2;
   logic        c_we, c_we2;
   logic [63:0] c_rd1, c_rd2;
   logic        c_rdy;

   typedef struct {
      string       tag;
      logic [63:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   mips_regfile_param dut_a (
      .clk(clk), .rst_n(rst_n),
      .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
      .read_data_1(a_rd1), .read_data_2(a_rd2),
      .write_reg(write_reg), .write_data(write_data), .signal_reg_write(signal_reg_write),
      .write_reg2(write_reg2), .write_data2(write_data2), .signal_reg_write2(signal_reg_write2),
      .ready(a_rdy)
   );

   mips_regfile_param #(.BYPASS(0)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
      .read_data_1(b_rd1), .read_data_2(b_rd2),
      .write_reg(write_reg), .write_data(write_data), .signal_reg_write(signal_reg_write),
      .write_reg2(write_reg2), .write_data2(write_data2), .signal_reg_write2(signal_reg_write2),
      .ready(b_rdy)
   );

   mips_regfile_param #(.DATA_W(64), .ADDR_W(3), .ZERO_REG(0)) dut_c (
      .clk(clk), .rst_n(rst_n),
      .read_reg_1(c_rr1), .read_reg_2(c_rr2),
      .read_data_1(c_rd1), .read_data_2(c_rd2),
      .write_reg(c_wr), .write_data(c_wd), .signal_reg_write(c_we),
      .write_reg2(c_wr2), .write_data2(c_wd2), .signal_reg_write2(c_we2),
      .ready(c_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_exp(input string tag, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp(input logic [63:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed=%h expected=<queued value>", obs);
      end else begin
         e = sb_q.pop_front();
         n_cmp++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic idle_ports();
      signal_reg_write  = 1'b0;
      signal_reg_write2 = 1'b0;
      write_reg  = 5'd0;
      write_reg2 = 5'd0;
      write_data  = 32'd0;
      write_data2 = 32'd0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle_ports();
      read_reg_1 = 5'd20;
      read_reg_2 = 5'd0;
      c_rr1 = 3'd3; c_rr2 = 3'd0; c_wr = 3'd0; c_wr2 = 3'd0;
      c_wd = 64'd0; c_wd2 = 64'd0; c_we = 1'b0; c_we2 = 1'b0;

      // 1. reset for two edges, then count the sweep
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      push_exp("rst_ready_a", 64'd0); pop_cmp(64'(a_rdy));
      push_exp("rst_rd_a", 64'd0);    pop_cmp(64'(a_rd1));
      push_exp("rst_rd_c", 64'd0);    pop_cmp(c_rd1);
      rst_n = 1'b1;
      #1;
      push_exp("rel_ready_a", 64'd0); pop_cmp(64'(a_rdy));
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         push_exp($sformatf("sweep_ready_a_%0d", i), 64'(i == 32)); pop_cmp(64'(a_rdy));
         push_exp($sformatf("sweep_ready_b_%0d", i), 64'(i == 32)); pop_cmp(64'(b_rdy));
         push_exp($sformatf("sweep_ready_c_%0d", i), 64'(i >= 8));  pop_cmp(64'(c_rdy));
         if (i == 2) begin
            push_exp("sweep_forced_c", 64'd0); pop_cmp(c_rd1);
         end
         if (i == 5) begin
            push_exp("sweep_forced_a", 64'd0); pop_cmp(64'(a_rd1));
         end
      end
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         read_reg_1 = 5'(i);
         read_reg_2 = 5'(31 - i);
         c_rr1 = 3'(i);
         #1;
         push_exp($sformatf("clr_rd1_%0d", i), 64'd0); pop_cmp(64'(a_rd1));
         push_exp($sformatf("clr_rd2_%0d", i), 64'd0); pop_cmp(64'(a_rd2));
         if (i < 8) begin
            push_exp($sformatf("clr_c_%0d", i), 64'd0); pop_cmp(c_rd1);
         end
      end

      // 6. wide variant: entry 0 is an ordinary register
      @(negedge clk);
      c_wr = 3'd0; c_wd = 64'h0123_4567_89AB_CDEF; c_we = 1'b1;
      @(negedge clk);
      c_we = 1'b0; c_rr1 = 3'd0;
      #1;
      push_exp("c_reg0", 64'h0123_4567_89AB_CDEF); pop_cmp(c_rd1);

      // 2. collision on reg 7: port 2 wins
      @(negedge clk);
      write_reg = 5'd7;  write_data  = 32'h1111_1111; signal_reg_write  = 1'b1;
      write_reg2 = 5'd7; write_data2 = 32'h2222_2222; signal_reg_write2 = 1'b1;
      read_reg_1 = 5'd7;
      #1;
      push_exp("coll_byp_a", 64'h2222_2222); pop_cmp(64'(a_rd1));
      push_exp("coll_old_b", 64'd0);         pop_cmp(64'(b_rd1));
      @(negedge clk);
      idle_ports();
      #1;
      push_exp("coll_a", 64'h2222_2222); pop_cmp(64'(a_rd1));
      push_exp("coll_b", 64'h2222_2222); pop_cmp(64'(b_rd1));

      // both ports to different addresses in one cycle
      @(negedge clk);
      write_reg = 5'd8;  write_data  = 32'h0808_0808; signal_reg_write  = 1'b1;
      write_reg2 = 5'd9; write_data2 = 32'h0909_0909; signal_reg_write2 = 1'b1;
      @(negedge clk);
      idle_ports();
      read_reg_1 = 5'd8; read_reg_2 = 5'd9;
      #1;
      push_exp("dual_a1", 64'h0808_0808); pop_cmp(64'(a_rd1));
      push_exp("dual_a2", 64'h0909_0909); pop_cmp(64'(a_rd2));
      push_exp("dual_b1", 64'h0808_0808); pop_cmp(64'(b_rd1));
      push_exp("dual_b2", 64'h0909_0909); pop_cmp(64'(b_rd2));

      // 3. zero register ignores writes and overrides bypass
      @(negedge clk);
      write_reg = 5'd0;  write_data  = 32'hDEAD_BEEF; signal_reg_write  = 1'b1;
      write_reg2 = 5'd0; write_data2 = 32'hDEAD_BEEF; signal_reg_write2 = 1'b1;
      read_reg_1 = 5'd0;
      #1;
      push_exp("zero_wcyc_a", 64'd0); pop_cmp(64'(a_rd1));
      push_exp("zero_wcyc_b", 64'd0); pop_cmp(64'(b_rd1));
      @(negedge clk);
      idle_ports();
      #1;
      push_exp("zero_after_a", 64'd0); pop_cmp(64'(a_rd1));
      push_exp("zero_after_b", 64'd0); pop_cmp(64'(b_rd1));

      // 4. bypass vs stored value on reg 5
      @(negedge clk);
      write_reg = 5'd5; write_data = 32'h1234_5678; signal_reg_write = 1'b1;
      @(negedge clk);
      write_reg = 5'd5; write_data = 32'hA5A5_A5A5; signal_reg_write = 1'b1;
      read_reg_1 = 5'd5;
      #1;
      push_exp("byp_a", 64'hA5A5_A5A5); pop_cmp(64'(a_rd1));
      push_exp("byp_old_b", 64'h1234_5678); pop_cmp(64'(b_rd1));
      @(negedge clk);
      idle_ports();
      #1;
      push_exp("byp_next_a", 64'hA5A5_A5A5); pop_cmp(64'(a_rd1));
      push_exp("byp_next_b", 64'hA5A5_A5A5); pop_cmp(64'(b_rd1));

      // port 2 bypass takes priority on a same-address collision
      @(negedge clk);
      write_reg = 5'd11;  write_data  = 32'hB1B1_B1B1; signal_reg_write  = 1'b1;
      write_reg2 = 5'd11; write_data2 = 32'hB2B2_B2B2; signal_reg_write2 = 1'b1;
      read_reg_1 = 5'd11; read_reg_2 = 5'd5;
      #1;
      push_exp("byp_prio_a", 64'hB2B2_B2B2); pop_cmp(64'(a_rd1));
      push_exp("byp_other_a", 64'hA5A5_A5A5); pop_cmp(64'(a_rd2));

      // port 1 write while idle port 2 carries X address/data
      @(negedge clk);
      write_reg = 5'd10; write_data = 32'h0A0A_0A0A; signal_reg_write = 1'b1;
      signal_reg_write2 = 1'b0; write_reg2 = 5'bxxxxx; write_data2 = 32'hxxxx_xxxx;
      read_reg_1 = 5'd10; read_reg_2 = 5'd11;
      #1;
      push_exp("xidle_byp_a", 64'h0A0A_0A0A); pop_cmp(64'(a_rd1));
      push_exp("xidle_old_b", 64'd0);         pop_cmp(64'(b_rd1));
      push_exp("xidle_r11_a", 64'hB2B2_B2B2); pop_cmp(64'(a_rd2));
      @(negedge clk);
      idle_ports();
      read_reg_2 = 5'd7;
      #1;
      push_exp("xidle_r10_b", 64'h0A0A_0A0A); pop_cmp(64'(b_rd1));
      push_exp("xidle_r7_a", 64'h2222_2222);  pop_cmp(64'(a_rd2));

      // 5. reset in run, then again at sweep cycle 10
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      push_exp("rst_run_ready", 64'd0); pop_cmp(64'(a_rdy));
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 32; i++) begin
         @(posedge clk);
         #1;
         push_exp($sformatf("resweep_ready_a_%0d", i), 64'(i == 32)); pop_cmp(64'(a_rdy));
         push_exp($sformatf("resweep_ready_c_%0d", i), 64'(i >= 8));  pop_cmp(64'(c_rdy));
         if (i == 25) begin
            write_reg = 5'd2;  write_data  = 32'hFFFF_0000; signal_reg_write  = 1'b1;
            write_reg2 = 5'd3; write_data2 = 32'h0000_FFFF; signal_reg_write2 = 1'b1;
         end
         if (i == 26) begin
            idle_ports();
         end
      end
      @(negedge clk);
      read_reg_1 = 5'd2; read_reg_2 = 5'd3; c_rr1 = 3'd0;
      #1;
      push_exp("sweep_wr_lost_1", 64'd0); pop_cmp(64'(a_rd1));
      push_exp("sweep_wr_lost_2", 64'd0); pop_cmp(64'(a_rd2));
      push_exp("resweep_c_reg0", 64'd0);  pop_cmp(c_rd1);
      @(negedge clk);
      read_reg_1 = 5'd7; read_reg_2 = 5'd8;
      #1;
      push_exp("resweep_r7", 64'd0); pop_cmp(64'(a_rd1));
      push_exp("resweep_r8", 64'd0); pop_cmp(64'(b_rd2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
